// File: rtl/sipo_frame_ctrl_if.sv
// Handshake/bus bundle for sipo_frame_ctrl: serial input side plus
// the valid/ready parallel output side.
interface sipo_frame_ctrl_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic             dir;
  logic             si;
  logic             out_ready;
  logic [WIDTH-1:0] po;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  // master = serial source / parallel consumer, slave = the capture controller
  modport master (
    output start, dir, si, out_ready,
    input  po, out_valid, busy, overrun
  );

  modport slave (
    input  start, dir, si, out_ready,
    output po, out_valid, busy, overrun
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame capture: shift SHIFT_BITS bits, freeze for
// HOLD_CYC cycles, then present the word under a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SHIFT_BITS = 2,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  sipo_frame_ctrl_if.slave  bus_io
);

  localparam int unsigned BcW = $clog2(SHIFT_BITS + 1);
  // Keep the hold counter at least one bit wide even when HOLD is skipped.
  localparam int unsigned HcW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [BcW-1:0] BitLast  = BcW'(SHIFT_BITS - 1);
  localparam logic [HcW-1:0] HoldLast = HcW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold,
    StOut
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [HcW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    po_d       = po_q;
    valid_d    = valid_q;
    // A start anywhere but IDLE is dropped and flagged, including in the
    // handshake cycle of OUT.
    overrun_d  = bus_io.start && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          dir_d     = bus_io.dir;
          shreg_d   = '0;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end

      StShift: begin
        if (dir_q) begin
          shreg_d = {shreg_q[WIDTH-2:0], bus_io.si};
        end else begin
          shreg_d = {bus_io.si, shreg_q[WIDTH-1:1]};
        end
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BitLast) begin
          if (HOLD_CYC > 0) begin
            hold_cnt_d = '0;
            state_d    = StHold;
          end else begin
            // No hold phase: the bit sampled this cycle must land in po.
            po_d    = shreg_d;
            valid_d = 1'b1;
            state_d = StOut;
          end
        end
      end

      StHold: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HoldLast) begin
          po_d    = shreg_q;
          valid_d = 1'b1;
          state_d = StOut;
        end
      end

      StOut: begin
        if (valid_q && bus_io.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      po_q       <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      po_q       <= po_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus_io.po        = po_q;
  assign bus_io.out_valid = valid_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: default instance plus an 8/8/0 instance, each
// tracked by a positional frame model and checked every cycle.
module tb_sipo_frame_ctrl;

  logic clk;
  logic rst;
  logic cmp_en;
  int   checks;
  int   errors;

  sipo_frame_ctrl_if #(.WIDTH(4)) bus0 ();
  sipo_frame_ctrl_if #(.WIDTH(8)) bus1 ();

  sipo_frame_ctrl #(
    .WIDTH      (4),
    .SHIFT_BITS (2),
    .HOLD_CYC   (2)
  ) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus0)
  );

  sipo_frame_ctrl #(
    .WIDTH      (8),
    .SHIFT_BITS (8),
    .HOLD_CYC   (0)
  ) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: t counts cycles since the accepted start; bit i (sampled in
  // cycle i+1) is placed directly at its final position in the word.
  typedef struct packed {
    logic [7:0] word;
    logic [7:0] po;
    logic       valid;
    logic       busy;
    logic       ovr;
    logic       dir;
    logic [7:0] t;
  } mstate_t;

  mstate_t m0;
  mstate_t m1;

  function automatic mstate_t mstep(mstate_t s, int w, int sb, int hc,
                                    logic r, logic st, logic d, logic si, logic rdy);
    mstate_t n;
    int      pos;
    n = s;
    if (r) begin
      n = '0;
      return n;
    end
    n.ovr = st && s.busy;
    if (!s.busy) begin
      if (st) begin
        n.busy = 1'b1;
        n.t    = 8'd1;
        n.dir  = d;
        n.word = '0;
      end
    end else if (s.valid) begin
      if (rdy) begin
        n.valid = 1'b0;
        n.busy  = 1'b0;
      end
    end else begin
      if (int'(s.t) <= sb) begin
        pos = s.dir ? (sb - int'(s.t)) : (w - sb + int'(s.t) - 1);
        n.word[pos] = si;
      end
      if (int'(s.t) == sb + hc) begin
        n.valid = 1'b1;
        n.po    = n.word;
      end
      n.t = s.t + 8'd1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= mstep(m0, 4, 2, 2, rst, bus0.start, bus0.dir, bus0.si, bus0.out_ready);
    m1 <= mstep(m1, 8, 8, 0, rst, bus1.start, bus1.dir, bus1.si, bus1.out_ready);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_po0",    8'(bus0.po),        m0.po);
      check("m_valid0", 8'(bus0.out_valid), 8'(m0.valid));
      check("m_busy0",  8'(bus0.busy),      8'(m0.busy));
      check("m_ovr0",   8'(bus0.overrun),   8'(m0.ovr));
      check("m_po1",    bus1.po,            m1.po);
      check("m_valid1", 8'(bus1.out_valid), 8'(m1.valid));
      check("m_busy1",  8'(bus1.busy),      8'(m1.busy));
      check("m_ovr1",   8'(bus1.overrun),   8'(m1.ovr));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] bits;
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst    = 1'b1;
    bus0.start = 1'b0; bus0.dir = 1'b0; bus0.si = 1'b0; bus0.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.dir = 1'b0; bus1.si = 1'b0; bus1.out_ready = 1'b0;
    cyc();
    cyc();
    cmp_en = 1'b1;
    check("rst_po0",    8'(bus0.po),        8'h00);
    check("rst_valid0", 8'(bus0.out_valid), 8'h00);
    check("rst_busy0",  8'(bus0.busy),      8'h00);
    check("rst_ovr0",   8'(bus0.overrun),   8'h00);
    check("rst_po1",    bus1.po,            8'h00);
    rst = 1'b0;

    // Right shift, si = 1,1 -> 4'b1100 valid in cycle 5
    bus0.out_ready = 1'b1; bus0.start = 1'b1; bus0.dir = 1'b0; cyc();
    bus0.start = 1'b0; bus0.si = 1'b1;
    check("r_busy_c1", 8'(bus0.busy), 8'h01); cyc();
    bus0.si = 1'b1; cyc();
    bus0.si = 1'b0; cyc();
    check("r_valid_c4", 8'(bus0.out_valid), 8'h00); cyc();
    check("r_valid_c5", 8'(bus0.out_valid), 8'h01);
    check("r_po_c5",    8'(bus0.po),        8'h0C); cyc();
    check("r_busy_c6",  8'(bus0.busy),      8'h00);
    check("r_valid_c6", 8'(bus0.out_valid), 8'h00);
    check("r_po_c6",    8'(bus0.po),        8'h0C);

    // Left shift, si = 1,0 with si toggling in HOLD, then backpressure
    bus0.out_ready = 1'b0; bus0.start = 1'b1; bus0.dir = 1'b1; cyc();
    bus0.start = 1'b0; bus0.si = 1'b1; cyc();
    bus0.si = 1'b0; cyc();
    bus0.si = 1'b1; cyc();
    bus0.si = 1'b0; cyc();
    check("l_valid_c5", 8'(bus0.out_valid), 8'h01);
    check("l_po_c5",    8'(bus0.po),        8'h02);
    for (int i = 0; i < 10; i++) begin
      bus0.si = ~bus0.si; bus0.dir = ~bus0.dir; cyc();
      check("bp_po",    8'(bus0.po),        8'h02);
      check("bp_valid", 8'(bus0.out_valid), 8'h01);
    end
    bus0.out_ready = 1'b1; cyc();
    bus0.out_ready = 1'b0;
    check("bp_busy_after", 8'(bus0.busy),      8'h00);
    check("bp_valid_after", 8'(bus0.out_valid), 8'h00);
    check("bp_po_after",   8'(bus0.po),        8'h02);

    // Overrun: start in cycle 2 (SHIFT) and cycle 5 (OUT handshake)
    bus0.out_ready = 1'b1; bus0.start = 1'b1; bus0.dir = 1'b0; cyc();
    bus0.start = 1'b0; bus0.si = 1'b0; cyc();
    bus0.start = 1'b1; bus0.dir = 1'b1; bus0.si = 1'b1; cyc();
    bus0.start = 1'b0; bus0.si = 1'b0;
    check("ov_c3", 8'(bus0.overrun), 8'h01); cyc();
    check("ov_c4", 8'(bus0.overrun), 8'h00); cyc();
    check("ov_valid_c5", 8'(bus0.out_valid), 8'h01);
    check("ov_po_c5",    8'(bus0.po),        8'h08);
    bus0.start = 1'b1; cyc();
    bus0.start = 1'b0;
    check("ov_c6",      8'(bus0.overrun), 8'h01);
    check("ov_busy_c6", 8'(bus0.busy),    8'h00); cyc();
    check("ov_busy_c7", 8'(bus0.busy),    8'h00);
    check("ov_c7",      8'(bus0.overrun), 8'h00);

    // Reset in HOLD (cycle 3), then a fresh right-shift frame si = 0,1
    bus0.start = 1'b1; bus0.dir = 1'b1; cyc();
    bus0.start = 1'b0; bus0.si = 1'b1; cyc();
    bus0.si = 1'b1; cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    check("rh_po",    8'(bus0.po),        8'h00);
    check("rh_valid", 8'(bus0.out_valid), 8'h00);
    check("rh_busy",  8'(bus0.busy),      8'h00);
    bus0.start = 1'b1; bus0.dir = 1'b0; cyc();
    bus0.start = 1'b0; bus0.si = 1'b0; cyc();
    bus0.si = 1'b1; cyc();
    bus0.si = 1'b0; cyc();
    cyc();
    check("rh_valid_c5", 8'(bus0.out_valid), 8'h01);
    check("rh_po_c5",    8'(bus0.po),        8'h08);
    cyc();

    // 8/8/0 instance, left shift of 1,0,1,1,0,0,1,0 -> 8'hB2 in cycle 9
    bits = 8'b1011_0010;
    bus1.out_ready = 1'b1; bus1.start = 1'b1; bus1.dir = 1'b1; cyc();
    bus1.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus1.si = bits[7-i];
      if (i == 7) check("w8_valid_c8", 8'(bus1.out_valid), 8'h00);
      cyc();
    end
    check("w8_valid_c9", 8'(bus1.out_valid), 8'h01);
    check("w8_po_c9",    bus1.po,            8'hB2); cyc();
    check("w8_busy_c10", 8'(bus1.busy),      8'h00);
    check("w8_po_c10",   bus1.po,            8'hB2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
